// File: rtl/ps2_keyboard_display.sv
// PS/2 keyboard receiver: conditions ps2c/ps2d, decodes 11-bit frames, keeps a
// two-deep scan-code history and drives four hex 7-segment digits from it.
//
// state  | meaning
// IDLE   | waiting for a start bit (filtered falling edge with ps2d low)
// DATA   | shifting in d0..d7, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | capturing the stop bit, committing the byte if the frame is good
module ps2_keyboard_display #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [6:0] prev_seg1,
  output logic [6:0] prev_seg0,
  output logic [6:0] curr_seg1,
  output logic [6:0] curr_seg0
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_TOP = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_TOP  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    c_sync_q, c_sync_d;
  logic [1:0]    d_sync_q, d_sync_d;
  logic          filt_q, filt_d;
  logic          filt_prev_q, filt_prev_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    prev_code_q, prev_code_d;
  logic [7:0]    curr_code_q, curr_code_d;

  logic c_s, d_s, fall;

  assign c_s  = c_sync_q[1];
  assign d_s  = d_sync_q[1];
  assign fall = filt_prev_q & ~filt_q;

  always_comb begin
    c_sync_d    = {c_sync_q[0], ps2c};
    d_sync_d    = {d_sync_q[0], ps2d};
    filt_d      = filt_q;
    fcnt_d      = fcnt_q;
    filt_prev_d = filt_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    prev_code_d = prev_code_q;
    curr_code_d = curr_code_q;

    // Down-counter of consecutive samples disagreeing with the filtered level.
    if (c_s == filt_q) begin
      fcnt_d = FILT_TOP;
    end else if (fcnt_q == '0) begin
      filt_d = c_s;
      fcnt_d = FILT_TOP;
    end else begin
      fcnt_d = fcnt_q - 1'b1;
    end

    if (state_q != IDLE && !fall) begin
      if (tmo_q == '0) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end

    // An edge always wins over an expiring timeout.
    if (fall) begin
      tmo_d = TMO_TOP;
      case (state_q)
        IDLE: begin
          if (!d_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {d_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = d_s;
          state_d = STOP;
        end
        STOP: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (d_s && (^{shift_q, par_q})) begin
            prev_code_d = curr_code_q;
            curr_code_d = shift_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_sync_q    <= 2'b11;
      d_sync_q    <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= FILT_TOP;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      prev_code_q <= '0;
      curr_code_q <= '0;
    end else begin
      c_sync_q    <= c_sync_d;
      d_sync_q    <= d_sync_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      prev_code_q <= prev_code_d;
      curr_code_q <= curr_code_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  assign prev_seg1 = seg7(prev_code_q[7:4]);
  assign prev_seg0 = seg7(prev_code_q[3:0]);
  assign curr_seg1 = seg7(curr_code_q[7:4]);
  assign curr_seg0 = seg7(curr_code_q[3:0]);

endmodule

// File: tb/tb_ps2_keyboard_display.sv
// Bench for ps2_keyboard_display: drives PS/2 frames and checks the displays
// against a code-history model every cycle plus hand-derived literal patterns.
module tb_ps2_keyboard_display;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [6:0] prev_seg1, prev_seg0, curr_seg1, curr_seg0;

  ps2_keyboard_display dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .prev_seg1 (prev_seg1),
    .prev_seg0 (prev_seg0),
    .curr_seg1 (curr_seg1),
    .curr_seg0 (curr_seg0)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  bit         check_en = 1'b0;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_curr = 8'h00;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic logic [6:0] seg(input logic [3:0] n);
    return hex_tab[n];
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model prev_seg1", prev_seg1, seg(m_prev[7:4]));
      chk("model prev_seg0", prev_seg0, seg(m_prev[3:0]));
      chk("model curr_seg1", curr_seg1, seg(m_curr[7:4]));
      chk("model curr_seg0", curr_seg0, seg(m_curr[3:0]));
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Frame bits LSB first: start, d0..d7, parity, stop.
  function automatic logic [10:0] mk(input logic [7:0] d, input bit par_ok, input bit stop);
    logic p;
    p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    if (!par_ok) p = ~p;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int nbits,
                           input int stall_at, input int stall_len);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) wait_clk(stall_len);
      ps2d = b[i];
      wait_clk(25);
      if (i == 10) check_en = 1'b0;
      ps2c = 1'b0;
      wait_clk(50);
      ps2c = 1'b1;
      wait_clk(25);
    end
    ps2d = 1'b1;
    if (nbits == 11) begin
      if (b[0] == 1'b0 && b[10] == 1'b1 && ($countones(b[9:1]) % 2 == 1)) begin
        m_prev = m_curr;
        m_curr = b[8:1];
      end
      wait_clk(5);
      check_en = 1'b1;
    end
  endtask

  task automatic lit(input string tag, input logic [6:0] ps1, input logic [6:0] ps0,
                     input logic [6:0] cs1, input logic [6:0] cs0);
    @(negedge clk);
    chk({tag, " prev_seg1"}, prev_seg1, ps1);
    chk({tag, " prev_seg0"}, prev_seg0, ps0);
    chk({tag, " curr_seg1"}, curr_seg1, cs1);
    chk({tag, " curr_seg0"}, curr_seg0, cs0);
  endtask

  initial begin
    wait_clk(3);
    reset_n = 1'b1;
    check_en = 1'b1;
    wait_clk(20);
    lit("reset", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

    send_bits(mk(8'h3A, 1'b1, 1'b1), 11, -1, 0);
    lit("3A", 7'b1000000, 7'b1000000, 7'b0110000, 7'b0001000);

    send_bits(mk(8'h11, 1'b1, 1'b1), 11, -1, 0);
    lit("11", 7'b0110000, 7'b0001000, 7'b1111001, 7'b1111001);

    send_bits(mk(8'h11, 1'b0, 1'b1), 11, -1, 0);
    lit("bad parity", 7'b0110000, 7'b0001000, 7'b1111001, 7'b1111001);
    send_bits(mk(8'h11, 1'b1, 1'b0), 11, -1, 0);
    lit("bad stop", 7'b0110000, 7'b0001000, 7'b1111001, 7'b1111001);

    ps2c = 1'b0;
    wait_clk(2);
    ps2c = 1'b1;
    wait_clk(50);
    send_bits(mk(8'hA5, 1'b1, 1'b1), 4, -1, 0);
    wait_clk(5200);
    send_bits(mk(8'hF0, 1'b1, 1'b1), 11, -1, 0);
    lit("F0", 7'b1111001, 7'b1111001, 7'b0001110, 7'b1000000);

    send_bits(mk(8'h24, 1'b1, 1'b1), 11, 5, 4000);
    lit("24 stall", 7'b0001110, 7'b1000000, 7'b0100100, 7'b0011001);
    send_bits(mk(8'h56, 1'b1, 1'b1), 11, -1, 0);
    send_bits(mk(8'h78, 1'b1, 1'b1), 11, -1, 0);
    send_bits(mk(8'h9B, 1'b1, 1'b1), 11, -1, 0);
    lit("9B", 7'b1111000, 7'b0000000, 7'b0010000, 7'b0000011);
    send_bits(mk(8'hDE, 1'b1, 1'b1), 11, -1, 0);
    lit("DE", 7'b0010000, 7'b0000011, 7'b0100001, 7'b0000110);

    send_bits(mk(8'h55, 1'b1, 1'b1), 5, -1, 0);
    check_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_prev = 8'h00;
    m_curr = 8'h00;
    check_en = 1'b1;
    wait_clk(20);
    lit("mid reset", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11, -1, 0);
    lit("1C", 7'b1000000, 7'b1000000, 7'b1111001, 7'b1000110);

    wait_clk(10);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
